// File: rtl/flags_ctrl_if.sv
// Bundle of request, flag and status signals between the pipeline and flags_ctrl.
// The master side is the pipeline or bench; the slave side is the flag controller.
interface flags_ctrl_if;
  logic       alu_req;
  logic [2:0] alu_flags;
  logic       mdu_req;
  logic [2:0] mdu_flags;
  logic       push;
  logic       pop;
  logic [2:0] cond;
  logic       alu_gnt;
  logic       mdu_gnt;
  logic       stall;
  logic       zf;
  logic       sf;
  logic       of;
  logic       cond_true;
  logic       stack_full;
  logic       stack_empty;
  logic       stack_err;

  modport master (
    output alu_req, alu_flags, mdu_req, mdu_flags, push, pop, cond,
    input  alu_gnt, mdu_gnt, stall, zf, sf, of, cond_true,
           stack_full, stack_empty, stack_err
  );

  modport slave (
    input  alu_req, alu_flags, mdu_req, mdu_flags, push, pop, cond,
    output alu_gnt, mdu_gnt, stall, zf, sf, of, cond_true,
           stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/flags_ctrl.sv
// Status flag register with ALU/MDU write arbitration, an interrupt shadow stack
// and branch condition evaluation on the registered flags.
module flags_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  flags_ctrl_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {PRI_MDU, PRI_ALU} arb_state_t;

  arb_state_t    arb_q, arb_next;
  logic [2:0]    flags_q;
  logic [CW-1:0] count;
  logic          stack_err_q;
  logic [2:0]    stack_mem [DEPTH];

  logic          alu_gnt_c, mdu_gnt_c;
  logic          push_only, pop_only;
  logic          full, empty;
  logic [AW-1:0] push_idx, pop_idx;
  logic          lt;
  logic          cond_c;

  assign push_only = bus.push & ~bus.pop;
  assign pop_only  = bus.pop & ~bus.push;
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign push_idx  = count[AW-1:0];
  assign pop_idx   = AW'(count - CW'(1));

  // Any pop blocks both writers; grants are also suppressed while in reset.
  always_comb begin
    alu_gnt_c = 1'b0;
    mdu_gnt_c = 1'b0;
    arb_next  = arb_q;
    if (rst_n && !bus.pop) begin
      if (bus.alu_req && bus.mdu_req) begin
        if (arb_q == PRI_MDU) mdu_gnt_c = 1'b1;
        else                  alu_gnt_c = 1'b1;
      end else begin
        alu_gnt_c = bus.alu_req;
        mdu_gnt_c = bus.mdu_req;
      end
    end
    if (mdu_gnt_c)      arb_next = PRI_ALU;
    else if (alu_gnt_c) arb_next = PRI_MDU;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_q       <= PRI_MDU;
      flags_q     <= '0;
      count       <= '0;
      stack_err_q <= 1'b0;
    end else begin
      arb_q       <= arb_next;
      stack_err_q <= (push_only && full) || (pop_only && empty);
      if (pop_only && !empty) begin
        flags_q <= stack_mem[pop_idx];
        count   <= count - CW'(1);
      end else begin
        if (alu_gnt_c)      flags_q <= bus.alu_flags;
        else if (mdu_gnt_c) flags_q <= bus.mdu_flags;
        if (push_only && !full) count <= count + CW'(1);
      end
    end
  end

  // Saved entries are the flags as they stood before this cycle's write.
  always_ff @(posedge clk) begin
    if (push_only && !full) stack_mem[push_idx] <= flags_q;
  end

  assign lt = flags_q[1] ^ flags_q[2];

  always_comb begin
    cond_c = 1'b0;
    case (bus.cond)
      3'b000: cond_c = 1'b1;
      3'b001: cond_c = flags_q[0];
      3'b010: cond_c = ~flags_q[0];
      3'b011: cond_c = lt;
      3'b100: cond_c = ~lt;
      3'b101: cond_c = ~flags_q[0] & ~lt;
      3'b110: cond_c = flags_q[0] | lt;
      3'b111: cond_c = flags_q[2];
      default: cond_c = 1'b0;
    endcase
  end

  assign bus.alu_gnt     = alu_gnt_c;
  assign bus.mdu_gnt     = mdu_gnt_c;
  assign bus.stall       = bus.alu_req & ~alu_gnt_c;
  assign bus.of          = flags_q[2];
  assign bus.sf          = flags_q[1];
  assign bus.zf          = flags_q[0];
  assign bus.cond_true   = cond_c;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = stack_err_q;

endmodule

// File: doc/flags_ctrl.md
# flags_ctrl

Clocked controller for the processor status flags (zero, sign, overflow). It owns the flag register and arbitrates flag updates between the single-cycle ALU and the multi-cycle multiply/divide unit (MDU). It keeps a shadow stack of flag values, saved on interrupt entry and restored on exception return. It also evaluates branch condition codes against the registered flags for the branch unit.

## Interface
- DEPTH, 4: shadow stack entries (≥1); occupancy counter width is clog2(DEPTH+1).
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_req  in  1  ALU requests a flag write this cycle.
- alu_flags  in  3  {of, sf, zf} from ALU.
- mdu_req  in  1  MDU requests a flag write (result retiring).
- mdu_flags  in  3  {of, sf, zf} from MDU.
- push  in  1  interrupt entry: save current flags.
- pop  in  1  exception return: restore flags from stack top.
- cond  in  3  branch condition code.
- alu_gnt  out  1  ALU write accepted this cycle (combinational).
- mdu_gnt  out  1  MDU write accepted this cycle (combinational).
- stall  out  1  alu_req asserted and not granted; the pipeline holds.
- zf, sf, of  out  1 each  registered flags.
- cond_true  out  1  condition result (combinational from registered flags).
- stack_full, stack_empty  out  1 each  shadow stack status.
- stack_err  out  1  one-cycle registered pulse on push-when-full or pop-when-empty.

## Operation
- Arbiter has two states, PRI_MDU and PRI_ALU; reset state is PRI_MDU.
- Both requests with no pop: the priority holder is granted, the other is not.
- Single requester with no pop: it is granted regardless of state.
- After an MDU grant, next state is PRI_ALU. After an ALU grant, next state is PRI_MDU. With no grant, state holds.
- A requester that is not granted must hold its req and data until granted. The MDU has no stall output; it observes mdu_gnt.
- Granted write: {of,sf,zf} ← granted source's flags at the clock edge.
- push only (no pop): stack[count] ← current registered flags, count+1. Grants and flag writes proceed normally that cycle. The saved value is the pre-write value.
- pop only: flags ← stack[count-1], count−1. Both grants are forced to 0 that cycle; stall = alu_req. The arbiter state holds.
- push and pop in the same cycle: net no-op on the stack and flags. Grants are blocked as for pop.
- push with count==DEPTH: ignored and stack_err pulses. Normal writes still proceed.
- pop with count==0: ignored, flags unchanged, stack_err pulses. Grants are still blocked.
- stack_full = (count==DEPTH); stack_empty = (count==0).
- cond decode (lt = sf^of):
  - 000: always.
  - 001: eq, zf.
  - 010: ne, !zf.
  - 011: lt.
  - 100: ge, !lt.
  - 101: gt, !zf & !lt.
  - 110: le, zf | lt.
  - 111: ov, of.

## Timing
- Reset (asynchronous, while rst_n=0):
  - zf=sf=of=0 and count=0, so stack_empty=1 and stack_full=0.
  - stack_err=0 and the arbiter is in PRI_MDU.
  - cond_true follows decode of zero flags (1 for 000, 010, 100, 101).
  - Stack contents are don't-care.
- Reset mid-operation: all pending saves are discarded. No grant or pulse is produced after rst_n falls.
- Grants are combinational in the request cycle N. The new flags are visible on zf/sf/of and cond_true in cycle N+1.
- Pop in cycle N: restored flags visible in N+1.
- stack_err is asserted for exactly cycle N+1 after the offending request.
- Only the registered flags feed cond_true. A write in cycle N does not affect cond_true until N+1; there is no bypass.

## Test plan
- Reset, then ALU write 3'b001 with alu_req=1: alu_gnt=1 and stall=0; next cycle zf=1, and cond=001 gives cond_true=1.
- ALU (3'b010) and MDU (3'b100) request together from reset:
  - Cycle 1: mdu_gnt=1, stall=1; next flags of=1.
  - Cycle 2 (both still asserted): alu_gnt=1; next flags sf=1.
  - Cycle 3: MDU granted again.
- Flags=3'b010, push, then write 3'b001, then pop:
  - Stack holds 010 and count goes 0→1→0.
  - The pop cycle shows alu_gnt=0 and stall=1 if alu_req.
  - Flags return to 010.
- DEPTH=4, five consecutive pushes: stack_full=1 after the 4th; the 5th gives stack_err=1 for one cycle and count stays 4. Then five pops: the 5th gives stack_err and flags hold the first-saved value.
- Sweep cond 000–111 for each of the eight flag values, checking against the decode table, including lt with sf=1, of=1 (lt=0).
- Assert rst_n=0 mid-sequence with count=2 and flags=3'b111: outputs immediately clear to the reset values, and after release a pop gives stack_err.
